// File: rtl/cam_table_ctrl.sv
// Command-driven controller for a small CAM table with per-entry valid bits.
// Serialises SEARCH/WRITE/DELETE/CLEAR as IDLE -> MATCH -> EXEC -> RESP, one response per command.
module cam_table_ctrl #(
  parameter  int DEPTH      = 16,
  parameter  int KEY_WIDTH  = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [KEY_WIDTH-1:0]  cmd_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  // Handshakes: a command transfers on a rising edge with cmd_valid & cmd_ready;
  // a response transfers on a rising edge with rsp_valid & rsp_ready, and rsp_*
  // hold stable from rsp_valid rising until that transfer.

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [KEY_WIDTH-1:0]  keys_q [DEPTH];
  logic [KEY_WIDTH-1:0]  keys_d [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  fvalid_q, fvalid_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DEPTH-1:0]      match_c;
  logic                  hit_c, fvalid_c;
  logic [ADDR_WIDTH-1:0] maddr_c, faddr_c;

  // Two lowest-index-wins encoders: on the match vector and on the free slots.
  always_comb begin
    match_c  = '0;
    hit_c    = 1'b0;
    maddr_c  = '0;
    fvalid_c = 1'b0;
    faddr_c  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_c[i] = valid_q[i] && (keys_q[i] == key_q);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_c[i]) begin
        hit_c   = 1'b1;
        maddr_c = ADDR_WIDTH'(i);
      end
      if (!valid_q[i]) begin
        fvalid_c = 1'b1;
        faddr_c  = ADDR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    valid_d     = valid_q;
    keys_d      = keys_q;
    count_d     = count_q;
    hit_d       = hit_q;
    maddr_d     = maddr_q;
    fvalid_d    = fvalid_q;
    faddr_d     = faddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          key_d   = cmd_key;
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        hit_d    = hit_c;
        maddr_d  = maddr_c;
        fvalid_d = fvalid_c;
        faddr_d  = faddr_c;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_hit_d   = 1'b0;
        rsp_addr_d  = '0;
        rsp_err_d   = 1'b0;
        unique case (op_q)
          OP_SEARCH: begin
            rsp_hit_d  = hit_q;
            rsp_addr_d = hit_q ? maddr_q : '0;
          end
          OP_WRITE: begin
            if (hit_q) begin
              rsp_hit_d  = 1'b1;
              rsp_addr_d = maddr_q;
            end else if (fvalid_q) begin
              keys_d[faddr_q]  = key_q;
              valid_d[faddr_q] = 1'b1;
              count_d          = count_q + CNT_ONE;
              rsp_addr_d       = faddr_q;
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          OP_DELETE: begin
            if (hit_q) begin
              valid_d[maddr_q] = 1'b0;
              count_d          = count_q - CNT_ONE;
              rsp_hit_d        = 1'b1;
              rsp_addr_d       = maddr_q;
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          OP_CLEAR: begin
            valid_d = '0;
            count_d = '0;
          end
          default: ;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SEARCH;
      key_q       <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      maddr_q     <= '0;
      fvalid_q    <= 1'b0;
      faddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      maddr_q     <= maddr_d;
      fvalid_q    <= fvalid_d;
      faddr_q     <= faddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Key storage carries no reset; entries are only meaningful behind their valid bit.
  always_ff @(posedge clk) begin
    keys_q <= keys_d;
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);

endmodule
